ps2_kbd_fifo: RTL

PS/2 keyboard receiver for the 8-bit computer. Fully synchronous to CLOCK_50, with a parametrised glitch filter, odd-parity and framing checks, and a frame timeout. Decodes scan-code set 2, including F0 break and E0 extended prefixes, Shift/Ctrl state and arrow keys, into high-bit-set ASCII. Buffers decoded characters in a first-word-fall-through FIFO read by the CPU keyboard port.

---
 rtl/ps2_kbd_fifo_if.sv | 23 ++
 rtl/ps2_kbd_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_fifo_if.sv
// CPU-side keyboard port: FIFO head/pop handshake plus sticky error flags.
// The CPU is the master; the keyboard receiver drives the slave side.
interface ps2_kbd_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  logic                          rd_en;
  logic                          err_clr;
  logic [7:0]                    q;
  logic                          q_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          frame_err;

  modport master (
    output rd_en, err_clr,
    input  q, q_valid, fifo_count, overflow, frame_err
  );

  modport slave (
    input  rd_en, err_clr,
    output q, q_valid, fifo_count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_kbd_fifo.sv
// PS/2 set-2 keyboard receiver: filtered line sampling, framed byte receive, ASCII decode, FWFT FIFO.
// Define LOWERCASE_EN to add a Caps Lock register (scan code 58) and lowercase letters.
module ps2_kbd_fifo #(
  parameter int FILTER_LEN  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic           CLOCK_50,
  input logic           clr,
  input logic           PS2_CLK,
  input logic           PS2_DAT,
  ps2_kbd_fifo_if.slave bus
);
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYC - 1);
  localparam logic [PW:0]    FULL     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic clk_f_q, clk_f_d, dat_f_q, dat_f_d, clk_f_prev_q;
  logic [FCW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d, rx_byte_q, rx_byte_d;
  logic par_q, par_d, rx_valid_q, rx_valid_d, frame_bad, sample;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic brk_q, brk_d, ext_q, ext_d, shift_q, shift_d, ctrl_q, ctrl_d;
`ifdef LOWERCASE_EN
  logic caps_q, caps_d;
`endif
  logic [4:0] let_idx;
  logic [3:0] dig;
  logic [7:0] dig_shift, code;
  logic is_let, is_dig, push, pop, wr, ovf_set;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic overflow_q, overflow_d, frame_err_q, frame_err_d;

  // A filtered line flips only after FILTER_LEN consecutive opposite samples.
  function automatic logic [FCW:0] filt_step(logic s, logic f, logic [FCW-1:0] c);
    if (s == f)
      return {f, {FCW{1'b0}}};
    else if (c == FLT_LAST)
      return {s, {FCW{1'b0}}};
    else
      return {f, FCW'(c + 1'b1)};
  endfunction

  always_comb begin
    {clk_f_d, clk_cnt_d} = filt_step(clk_s2_q, clk_f_q, clk_cnt_q);
    {dat_f_d, dat_cnt_d} = filt_step(dat_s2_q, dat_f_q, dat_cnt_q);
  end

  assign sample = clk_f_prev_q & ~clk_f_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    frame_bad  = 1'b0;
    if (sample) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: if (!dat_f_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shreg_d   = {dat_f_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_f_q;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (dat_f_q && (^{par_q, shreg_q})) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shreg_q;
          end else begin
            frame_bad = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d   = IDLE;
        frame_bad = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TCW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_comb begin
    is_let  = 1'b1;
    let_idx = 5'd0;
    case (rx_byte_q)
      8'h1C: let_idx = 5'd0;   8'h32: let_idx = 5'd1;   8'h21: let_idx = 5'd2;
      8'h23: let_idx = 5'd3;   8'h24: let_idx = 5'd4;   8'h2B: let_idx = 5'd5;
      8'h34: let_idx = 5'd6;   8'h33: let_idx = 5'd7;   8'h43: let_idx = 5'd8;
      8'h3B: let_idx = 5'd9;   8'h42: let_idx = 5'd10;  8'h4B: let_idx = 5'd11;
      8'h3A: let_idx = 5'd12;  8'h31: let_idx = 5'd13;  8'h44: let_idx = 5'd14;
      8'h4D: let_idx = 5'd15;  8'h15: let_idx = 5'd16;  8'h2D: let_idx = 5'd17;
      8'h1B: let_idx = 5'd18;  8'h2C: let_idx = 5'd19;  8'h3C: let_idx = 5'd20;
      8'h2A: let_idx = 5'd21;  8'h1D: let_idx = 5'd22;  8'h22: let_idx = 5'd23;
      8'h35: let_idx = 5'd24;  8'h1A: let_idx = 5'd25;
      default: is_let = 1'b0;
    endcase
    is_dig = 1'b1;
    dig    = 4'd0;
    case (rx_byte_q)
      8'h45: dig = 4'd0;  8'h16: dig = 4'd1;  8'h1E: dig = 4'd2;  8'h26: dig = 4'd3;
      8'h25: dig = 4'd4;  8'h2E: dig = 4'd5;  8'h36: dig = 4'd6;  8'h3D: dig = 4'd7;
      8'h3E: dig = 4'd8;  8'h46: dig = 4'd9;
      default: is_dig = 1'b0;
    endcase
    case (dig)
      4'd0: dig_shift = 8'hA9;  4'd1: dig_shift = 8'hA1;  4'd2: dig_shift = 8'hC0;
      4'd3: dig_shift = 8'hA3;  4'd4: dig_shift = 8'hA4;  4'd5: dig_shift = 8'hA5;
      4'd6: dig_shift = 8'hDE;  4'd7: dig_shift = 8'hA6;  4'd8: dig_shift = 8'hAA;
      default: dig_shift = 8'hA8;
    endcase
  end

  // Prefix bytes only arm brk/ext; every other byte consumes and clears them.
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
`ifdef LOWERCASE_EN
    caps_d  = caps_q;
`endif
    push = 1'b0;
    code = 8'h00;
    if (rx_valid_q) begin
      if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (rx_byte_q == 8'h12 || rx_byte_q == 8'h59) begin
          shift_d = !brk_q;
        end else if (rx_byte_q == 8'h14) begin
          ctrl_d = !brk_q;
`ifdef LOWERCASE_EN
        end else if (rx_byte_q == 8'h58) begin
          if (!brk_q) caps_d = !caps_q;
`endif
        end else if (!brk_q) begin
          push = 1'b1;
          if (ext_q) begin
            case (rx_byte_q)
              8'h6B: code = 8'h88;
              8'h74: code = 8'h95;
              8'h75: code = 8'h8B;
              8'h72: code = 8'h8A;
              default: push = 1'b0;
            endcase
          end else if (is_let) begin
            if (ctrl_q)
              code = 8'h81 + {3'b000, let_idx};
`ifdef LOWERCASE_EN
            else if (!(shift_q ^ caps_q))
              code = 8'hE1 + {3'b000, let_idx};
`endif
            else
              code = 8'hC1 + {3'b000, let_idx};
          end else if (is_dig) begin
            code = shift_q ? dig_shift : (8'hB0 + {4'h0, dig});
          end else begin
            case (rx_byte_q)
              8'h52: code = shift_q ? 8'hA2 : 8'hA7;
              8'h55: code = shift_q ? 8'hAB : 8'hBD;
              8'h4C: code = shift_q ? 8'hBA : 8'hBB;
              8'h41: code = shift_q ? 8'hBC : 8'hAC;
              8'h49: code = shift_q ? 8'hBE : 8'hAE;
              8'h4A: code = shift_q ? 8'hBF : 8'hAF;
              8'h4E: code = 8'hAD;
              8'h29: code = 8'hA0;
              8'h5A: code = 8'h8D;
              8'h76: code = 8'h9B;
              8'h66: code = 8'h88;
              default: push = 1'b0;
            endcase
          end
        end
      end
    end
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  always_comb begin
    pop      = bus.rd_en && (count_q != '0);
    wr       = push && ((count_q != FULL) || pop);
    ovf_set  = push && (count_q == FULL) && !pop;
    wr_ptr_d = wr  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({wr, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = code;
    overflow_d  = (overflow_q  & ~bus.err_clr) | ovf_set;
    frame_err_d = (frame_err_q & ~bus.err_clr) | frame_bad;
  end

  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_f_q      <= 1'b1;
      dat_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      clk_cnt_q    <= '0;
      dat_cnt_q    <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= 8'h00;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      shift_q      <= 1'b0;
      ctrl_q       <= 1'b0;
`ifdef LOWERCASE_EN
      caps_q       <= 1'b0;
`endif
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= PS2_CLK;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= PS2_DAT;
      dat_s2_q     <= dat_s1_q;
      clk_f_q      <= clk_f_d;
      dat_f_q      <= dat_f_d;
      clk_f_prev_q <= clk_f_q;
      clk_cnt_q    <= clk_cnt_d;
      dat_cnt_q    <= dat_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      shift_q      <= shift_d;
      ctrl_q       <= ctrl_d;
`ifdef LOWERCASE_EN
      caps_q       <= caps_d;
`endif
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
  end

  assign bus.q          = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.q_valid    = (count_q != '0);
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.frame_err  = frame_err_q;
endmodule
